serial_comparator_gen: RTL and testbench
========================================

Name: serial_comparator_gen

Overview:
- Parametrised streaming comparator for multi-digit field operands, used in the fp_sub_and_add datapath for conditional subtract and reduction decisions.
- Consumes one RADIX-bit digit pair per valid beat, DIGITS beats per operand.
- Digit order is selectable by parameter; signed or unsigned compare is selectable per operation.
- Produces registered gt/eq/lt flags with a done pulse and a busy/ready handshake.
- Uses O(1) state regardless of DIGITS; there is no per-digit flag array.

Parameters:
- RADIX, 32, digit width in bits (>=2).
- DIGITS, 14, digits per operand (>=1, any value, not restricted to a power of two).
- MSB_FIRST, 0, 0 = digit 0 is least significant; 1 = digit 0 is most significant.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- start  in  1  begin operation; accepted only in IDLE
- cmp_signed  in  1  sampled on accepted start; 1 = operands are two's complement
- abort  in  1  synchronous cancel; returns to IDLE, no done
- digit_valid  in  1  digit pair present this cycle
- digit_a  in  RADIX  digit of A
- digit_b  in  RADIX  digit of B
- busy  out  1  high in RUN
- done  out  1  one-cycle pulse; result valid
- a_gt_b  out  1  A > B
- a_eq_b  out  1  A == B
- a_lt_b  out  1  A < B

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, cnt=0, done=0, busy=0.
  - a_gt_b=0, a_eq_b=0, a_lt_b=0.
  - Internal rel=EQ, lock=0, sgn=0.
- FSM states: IDLE, RUN. busy = (state==RUN).
- Start handling:
  - IDLE & start: sgn<=cmp_signed; rel<=EQ; lock<=0; cnt<=0; state<=RUN.
  - If digit_valid is also high in the start cycle, that digit is consumed as digit 0.
  - start in RUN is ignored.
  - digit_valid in IDLE, when start is not asserted, is ignored.
- Digit compare, per consumed digit k (cnt==k):
  - Significance: the top digit is k==DIGITS-1 when MSB_FIRST=0, and k==0 when MSB_FIRST=1.
  - The top digit compares signed if sgn=1; all other digits compare unsigned.
  - d = GT / EQ / LT of the digit pair.
- Update rule:
  - MSB_FIRST=0: if d!=EQ then rel<=d; otherwise rel is held. The last differing digit wins.
  - MSB_FIRST=1: if !lock and d!=EQ then rel<=d and lock<=1. The first differing digit wins.
- Count and completion:
  - cnt increments on each consumed digit.
  - On the digit with cnt==DIGITS-1: state<=IDLE, cnt<=0.
- Result timing:
  - In the next cycle done=1 and a_gt_b/a_eq_b/a_lt_b reflect the final relation, including that last digit.
  - Latency: done one cycle after the last digit beat.
  - Exactly one flag is high while done=1.
  - Flags hold their value until the next accepted start, at which point all three are cleared to 0.
- Back-to-back operation: start is legal in the cycle done is high, because state is already IDLE.
- Gaps: digit_valid low in RUN stalls, with no state change. There is no timeout.
- Abort:
  - abort in any state: state<=IDLE, cnt<=0, no done pulse, flags cleared to 0.
  - abort has priority over start and digit_valid in the same cycle.
- Reset mid-operation: all state returns immediately to the reset values; a pending done is not issued.
- DIGITS=1: start with digit_valid produces done the next cycle. The single digit is the top digit.
- Width: cnt is CLOG2(DIGITS) bits, minimum 1 bit. No wrap past DIGITS-1.

Test Plan:
- Test 1, MSB_FIRST=0, unsigned, DIGITS=14.
  - A=B except digit 13: a=0x1, b=0x0; digit 0: a=0x0, b=0xFFFFFFFF.
  - Required: done one cycle after beat 13; a_gt_b=1, a_eq_b=0, a_lt_b=0.
- Test 2, equal operands, random 448-bit value streamed with 3 random idle gaps.
  - Required: a_eq_b=1, busy high throughout, done exactly once.
- Test 3, signed, MSB_FIRST=0.
  - Top digit a=0x80000000, b=0x7FFFFFFF; lower digits a>b.
  - Required: a_lt_b=1.
  - Same stimulus with cmp_signed=0: required a_gt_b=1.
- Test 4, MSB_FIRST=1.
  - Digit 0: a=5, b=5. Digit 1: a=2, b=9. Digit 2: a=9, b=1.
  - Required: a_lt_b=1, because the first differing digit locks the result.
- Test 5, abort and start while busy.
  - Assert abort at beat 7: required no done, flags 0, busy=0 next cycle.
  - Then start+digit_valid in the same cycle: that digit counts as digit 0, done after 14 beats.
  - start pulses during RUN: no effect.
- Test 6, reset and back-to-back.
  - Assert rst asynchronously mid-operation: outputs 0 immediately.
  - Two operations back-to-back with start in the done cycle: two done pulses 14 beats apart, correct independent results.

Source files
------------

// File: rtl/serial_comparator_gen.sv
// Streaming magnitude comparator for multi-digit operands.
// The operands arrive one RADIX-bit digit pair per valid beat, DIGITS beats
// per operand, least or most significant digit first. A running relation
// (GT/EQ/LT) is folded digit by digit, so the state stays O(1) in DIGITS.
// The final relation is presented on registered flags with a one-cycle done.
module serial_comparator_gen #(
  parameter int RADIX     = 32,
  parameter int DIGITS    = 14,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             cmp_signed,
  input  logic             abort,
  input  logic             digit_valid,
  input  logic [RADIX-1:0] digit_a,
  input  logic [RADIX-1:0] digit_b,
  output logic             busy,
  output logic             done,
  output logic             a_gt_b,
  output logic             a_eq_b,
  output logic             a_lt_b
);

  localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(DIGITS - 1);
  localparam logic [CW-1:0] TOP_CNT  = MSB_FIRST ? '0 : LAST_CNT;

  typedef enum logic {IDLE, RUN} state_t;
  typedef enum logic [1:0] {REL_EQ = 2'd0, REL_GT = 2'd1, REL_LT = 2'd2} rel_t;

  state_t        state;
  rel_t          rel;
  logic          lock;
  logic          sgn;
  logic [CW-1:0] cnt;

  // Values seen by the digit being consumed this cycle. In the start cycle
  // the fresh operation's initial values apply, not the stale registers.
  logic          accept_start;
  logic          consume;
  logic          cur_sgn;
  logic          cur_lock;
  logic [CW-1:0] cur_cnt;
  rel_t          cur_rel;
  rel_t          dig_rel;
  rel_t          new_rel;
  logic          new_lock;
  logic          is_last;

  assign busy = (state == RUN);

  // Fold the current digit pair into the running relation.
  // NOTE: every always_comb output gets a default first so no path leaves
  // a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    accept_start = (state == IDLE) && start;
    consume      = digit_valid && (accept_start || (state == RUN));
    cur_sgn      = accept_start ? cmp_signed : sgn;
    cur_lock     = accept_start ? 1'b0       : lock;
    cur_cnt      = accept_start ? '0         : cnt;
    cur_rel      = accept_start ? REL_EQ     : rel;
    is_last      = (cur_cnt == LAST_CNT);

    dig_rel = REL_EQ;
    if ((cur_cnt == TOP_CNT) && cur_sgn) begin
      if ($signed(digit_a) > $signed(digit_b))      dig_rel = REL_GT;
      else if ($signed(digit_a) < $signed(digit_b)) dig_rel = REL_LT;
    end else begin
      if (digit_a > digit_b)      dig_rel = REL_GT;
      else if (digit_a < digit_b) dig_rel = REL_LT;
    end

    new_rel  = cur_rel;
    new_lock = cur_lock;
    if (MSB_FIRST) begin
      // First differing digit is the most significant one: lock it in.
      if (!cur_lock && (dig_rel != REL_EQ)) begin
        new_rel  = dig_rel;
        new_lock = 1'b1;
      end
    end else begin
      // Later digits are more significant: the last difference wins.
      if (dig_rel != REL_EQ) new_rel = dig_rel;
    end
  end

  // Control FSM, operand state and registered result flags.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values; later assignments in this block override
  // earlier ones on purpose (e.g. completion overrides the start transition).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      rel    <= REL_EQ;
      lock   <= 1'b0;
      sgn    <= 1'b0;
      cnt    <= '0;
      done   <= 1'b0;
      a_gt_b <= 1'b0;
      a_eq_b <= 1'b0;
      a_lt_b <= 1'b0;
    end else if (abort) begin
      state  <= IDLE;
      cnt    <= '0;
      done   <= 1'b0;
      a_gt_b <= 1'b0;
      a_eq_b <= 1'b0;
      a_lt_b <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept_start) begin
        sgn    <= cmp_signed;
        rel    <= REL_EQ;
        lock   <= 1'b0;
        cnt    <= '0;
        state  <= RUN;
        a_gt_b <= 1'b0;
        a_eq_b <= 1'b0;
        a_lt_b <= 1'b0;
      end
      if (consume) begin
        rel  <= new_rel;
        lock <= new_lock;
        if (is_last) begin
          state  <= IDLE;
          cnt    <= '0;
          done   <= 1'b1;
          a_gt_b <= (new_rel == REL_GT);
          a_eq_b <= (new_rel == REL_EQ);
          a_lt_b <= (new_rel == REL_LT);
        end else begin
          cnt <= cur_cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_comparator_gen.sv
// Self-checking bench for serial_comparator_gen. Two 14-digit instances
// (LSB-first and MSB-first) share one input stream; a third instance with a
// single digit covers the DIGITS=1 corner. Expected relations come from
// assembling the full operands and comparing them as wide integers.
module tb_serial_comparator_gen;

  localparam int R = 32;
  localparam int D = 14;
  localparam int W = R * D;

  logic         clk = 1'b0;
  logic         rst;
  logic         start, cmp_signed, abort, digit_valid;
  logic [R-1:0] digit_a, digit_b;
  logic         busy0, done0, gt0, eq0, lt0;
  logic         busy1, done1, gt1, eq1, lt1;

  logic         s_start, s_sgn, s_abort, s_valid;
  logic [R-1:0] s_a, s_b;
  logic         busy2, done2, gt2, eq2, lt2;

  logic [R-1:0] da [D];
  logic [R-1:0] db [D];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  serial_comparator_gen #(.RADIX(R), .DIGITS(D), .MSB_FIRST(1'b0)) dut0 (
    .clk(clk), .rst(rst), .start(start), .cmp_signed(cmp_signed), .abort(abort),
    .digit_valid(digit_valid), .digit_a(digit_a), .digit_b(digit_b),
    .busy(busy0), .done(done0), .a_gt_b(gt0), .a_eq_b(eq0), .a_lt_b(lt0));

  serial_comparator_gen #(.RADIX(R), .DIGITS(D), .MSB_FIRST(1'b1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .cmp_signed(cmp_signed), .abort(abort),
    .digit_valid(digit_valid), .digit_a(digit_a), .digit_b(digit_b),
    .busy(busy1), .done(done1), .a_gt_b(gt1), .a_eq_b(eq1), .a_lt_b(lt1));

  serial_comparator_gen #(.RADIX(R), .DIGITS(1), .MSB_FIRST(1'b0)) dut2 (
    .clk(clk), .rst(rst), .start(s_start), .cmp_signed(s_sgn), .abort(s_abort),
    .digit_valid(s_valid), .digit_a(s_a), .digit_b(s_b),
    .busy(busy2), .done(done2), .a_gt_b(gt2), .a_eq_b(eq2), .a_lt_b(lt2));

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Reference relation {gt,eq,lt} of the full operands held in da/db.
  function automatic logic [2:0] model_rel(input bit msb_first, input bit sgn);
    logic [W-1:0] a, b;
    int p;
    a = '0;
    b = '0;
    for (int k = 0; k < D; k++) begin
      p = msb_first ? (D - 1 - k) : k;
      a[p*R +: R] = da[k];
      b[p*R +: R] = db[k];
    end
    if (sgn) return {$signed(a) > $signed(b), a == b, $signed(a) < $signed(b)};
    return {a > b, a == b, a < b};
  endfunction

  task automatic fill_rand(input int eq_pct);
    for (int k = 0; k < D; k++) begin
      da[k] = $urandom;
      db[k] = ($urandom_range(0, 99) < eq_pct) ? da[k] : $urandom;
    end
  endtask

  task automatic put_digit(input int k);
    digit_valid = 1'b1;
    digit_a     = da[k];
    digit_b     = db[k];
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Stream one full operation through dut0/dut1 and check the result.
  task automatic stream(input string tag, input bit sgn, input int ngaps,
                        input bit with_digit, input bit spurious);
    int gaps_before [D];
    int k, early, not_busy;
    for (int i = 0; i < D; i++) gaps_before[i] = 0;
    for (int g = 0; g < ngaps; g++) gaps_before[$urandom_range(1, D - 1)]++;
    early    = 0;
    not_busy = 0;
    start      = 1'b1;
    cmp_signed = sgn;
    k = 0;
    if (with_digit) begin
      put_digit(0);
      k = 1;
    end
    step();
    start       = 1'b0;
    digit_valid = 1'b0;
    while (k < D) begin
      for (int g = 0; g < gaps_before[k]; g++) begin
        if (done0 || done1) early++;
        if (!busy0 || !busy1) not_busy++;
        start      = spurious && ($urandom_range(0, 1) == 1);
        cmp_signed = ~sgn;
        step();
      end
      if (done0 || done1) early++;
      if (!busy0 || !busy1) not_busy++;
      put_digit(k);
      start      = spurious && ($urandom_range(0, 1) == 1);
      cmp_signed = ~sgn;
      step();
      digit_valid = 1'b0;
      start       = 1'b0;
      k++;
    end
    check({tag, "_early_done"}, early, 0);
    check({tag, "_busy_run"}, not_busy, 0);
    check({tag, "_done0"}, done0, 1);
    check({tag, "_done1"}, done1, 1);
    check({tag, "_busy0_end"}, busy0, 0);
    check({tag, "_flags0"}, {gt0, eq0, lt0}, model_rel(1'b0, sgn));
    check({tag, "_flags1"}, {gt1, eq1, lt1}, model_rel(1'b1, sgn));
  endtask

  initial begin
    logic [R-1:0] ta, tb;
    bit sg;
    int late;

    rst = 1'b1;
    {start, cmp_signed, abort, digit_valid} = '0;
    digit_a = '0;
    digit_b = '0;
    {s_start, s_sgn, s_abort, s_valid} = '0;
    s_a = '0;
    s_b = '0;

    // Reset state
    #12;
    check("rst_busy0", busy0, 0);
    check("rst_done0", done0, 0);
    check("rst_flags0", {gt0, eq0, lt0}, 3'b000);
    check("rst_flags1", {gt1, eq1, lt1}, 3'b000);
    step();
    rst = 1'b0;
    step();

    // Test 1: top digit decides, LSB-first unsigned
    fill_rand(100);
    da[13] = 32'h1; db[13] = 32'h0;
    da[0]  = 32'h0; db[0]  = 32'hFFFF_FFFF;
    stream("t1", 1'b0, 0, 1'b0, 1'b0);
    check("t1_gt_explicit", {gt0, eq0, lt0}, 3'b100);
    // Abort in IDLE clears held flags
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("t1_abort_flags0", {gt0, eq0, lt0}, 3'b000);
    check("t1_abort_flags1", {gt1, eq1, lt1}, 3'b000);

    // Test 2: equal operands with three idle gaps
    fill_rand(100);
    stream("t2", 1'b0, 3, 1'b1, 1'b0);
    check("t2_eq_explicit", {gt0, eq0, lt0}, 3'b010);
    step();
    check("t2_done_once", done0, 0);
    check("t2_flags_hold", {gt0, eq0, lt0}, 3'b010);

    // Test 3: signed vs unsigned top digit
    for (int k = 0; k < D - 1; k++) begin
      db[k] = $urandom_range(0, 1000);
      da[k] = db[k] + 1;
    end
    da[13] = 32'h8000_0000;
    db[13] = 32'h7FFF_FFFF;
    stream("t3s", 1'b1, 1, 1'b1, 1'b0);
    check("t3s_lt_explicit", {gt0, eq0, lt0}, 3'b001);
    stream("t3u", 1'b0, 1, 1'b1, 1'b0);
    check("t3u_gt_explicit", {gt0, eq0, lt0}, 3'b100);

    // Test 4: MSB-first lock on the first differing digit
    fill_rand(100);
    da[0] = 5; db[0] = 5;
    da[1] = 2; db[1] = 9;
    da[2] = 9; db[2] = 1;
    stream("t4", 1'b0, 2, 1'b0, 1'b0);
    check("t4_lt_explicit", {gt1, eq1, lt1}, 3'b001);

    // Test 5: abort at beat 7, then restart with start+digit and start noise
    fill_rand(50);
    start = 1'b1;
    cmp_signed = 1'b0;
    put_digit(0);
    step();
    start = 1'b0;
    for (int k = 1; k < 7; k++) begin
      put_digit(k);
      step();
    end
    put_digit(7);
    abort = 1'b1;
    step();
    abort = 1'b0;
    digit_valid = 1'b0;
    check("t5_abort_busy", busy0, 0);
    check("t5_abort_done", done0, 0);
    check("t5_abort_flags", {gt0, eq0, lt0}, 3'b000);
    late = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (done0 || done1 || busy0) late++;
    end
    check("t5_quiet_after_abort", late, 0);
    fill_rand(40);
    stream("t5", 1'($urandom_range(0, 1)), 2, 1'b1, 1'b1);

    // Test 6: asynchronous reset mid-operation
    fill_rand(30);
    start = 1'b1;
    put_digit(0);
    step();
    start = 1'b0;
    for (int k = 1; k < 6; k++) begin
      put_digit(k);
      step();
    end
    digit_valid = 1'b0;
    #3;
    rst = 1'b1;
    #1;
    check("t6_rst_busy0", busy0, 0);
    check("t6_rst_busy1", busy1, 0);
    check("t6_rst_done", done0, 0);
    step();
    rst = 1'b0;
    late = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (done0 || done1 || busy0) late++;
    end
    check("t6_no_pending_done", late, 0);
    // Back-to-back: second start lands in the first done cycle
    fill_rand(20);
    stream("t6a", 1'b1, 0, 1'b1, 1'b0);
    fill_rand(20);
    stream("t6b", 1'b0, 0, 1'b1, 1'b0);

    // Randomized operations
    for (int n = 0; n < 8; n++) begin
      fill_rand($urandom_range(0, 90));
      if ($urandom_range(0, 1) == 1) begin
        da[13] = da[13] ^ 32'h8000_0000;
        da[0]  = db[0];
      end
      stream($sformatf("rnd%0d", n), 1'($urandom_range(0, 1)),
             $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // DIGITS=1: the single digit is the top digit, done next cycle
    for (int n = 0; n < 8; n++) begin
      ta = $urandom;
      tb = (n % 3 == 0) ? ta : $urandom;
      sg = 1'($urandom_range(0, 1));
      s_a = ta;
      s_b = tb;
      s_sgn = sg;
      s_start = 1'b1;
      s_valid = 1'b1;
      step();
      s_start = 1'b0;
      s_valid = 1'b0;
      check($sformatf("d1_done%0d", n), done2, 1);
      check($sformatf("d1_busy%0d", n), busy2, 0);
      if (sg)
        check($sformatf("d1_flags%0d", n), {gt2, eq2, lt2},
              {$signed(ta) > $signed(tb), ta == tb, $signed(ta) < $signed(tb)});
      else
        check($sformatf("d1_flags%0d", n), {gt2, eq2, lt2}, {ta > tb, ta == tb, ta < tb});
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
